// File: rtl/controle_execucao_pkg.sv
// Shared encodings for the execution-control block: board mode switches
// and the push-button debouncer states.
package controle_execucao_pkg;

  localparam logic [1:0] MODO_PAUSA    = 2'b00;
  localparam logic [1:0] MODO_LENTO    = 2'b01;
  localparam logic [1:0] MODO_MANUAL   = 2'b10;
  localparam logic [1:0] MODO_CONTINUO = 2'b11;

  typedef enum logic [1:0] {
    SOLTO          = 2'b00,
    CONFIRMA_PRESS = 2'b01,
    PRESSIONADO    = 2'b10,
    CONFIRMA_SOLTA = 2'b11
  } estado_deb_t;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int larg_cont(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/controle_execucao_debounce_botao.sv
// Push-button conditioner: two-flop synchronizer on the active-low button,
// a four-state confirm/hold FSM and a one-cycle event on an accepted press.
// Releases are confirmed the same way but never produce an event.
module debounce_botao
  import controle_execucao_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 1000000
) (
  input  logic clk_alta_f,
  input  logic rst,
  input  logic botao_n,
  output logic evento_botao
);

  localparam int            CW      = larg_cont(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic          btn_s1, btn_s2;
  estado_deb_t   estado, estado_prox;
  logic [CW-1:0] cnt, cnt_prox;

  // Synchronizer resets to 1 so a held-in-reset board reads as released.
  always_ff @(posedge clk_alta_f or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
    end else begin
      btn_s1 <= botao_n;
      btn_s2 <= btn_s1;
    end
  end

  // Debouncer state and stability counter.
  always_ff @(posedge clk_alta_f or posedge rst) begin
    if (rst) begin
      estado <= SOLTO;
      cnt    <= '0;
    end else begin
      estado <= estado_prox;
      cnt    <= cnt_prox;
    end
  end

  // Next state: any disagreeing sample aborts a confirmation window.
  always_comb begin
    estado_prox  = estado;
    cnt_prox     = cnt;
    evento_botao = 1'b0;
    case (estado)
      SOLTO: begin
        if (!btn_s2) begin
          estado_prox = CONFIRMA_PRESS;
          cnt_prox    = '0;
        end
      end
      CONFIRMA_PRESS: begin
        if (btn_s2) begin
          estado_prox = SOLTO;
        end else if (cnt == CNT_MAX) begin
          estado_prox  = PRESSIONADO;
          evento_botao = 1'b1;
        end else begin
          cnt_prox = cnt + 1'b1;
        end
      end
      PRESSIONADO: begin
        if (btn_s2) begin
          estado_prox = CONFIRMA_SOLTA;
          cnt_prox    = '0;
        end
      end
      CONFIRMA_SOLTA: begin
        if (!btn_s2) begin
          estado_prox = PRESSIONADO;
        end else if (cnt == CNT_MAX) begin
          estado_prox = SOLTO;
        end else begin
          cnt_prox = cnt + 1'b1;
        end
      end
      default: estado_prox = SOLTO;
    endcase
  end

endmodule

// File: rtl/controle_execucao.sv
// Execution control for the MIPS core: turns the slow divider clock, the
// manual button or continuous mode into a one-cycle clock-enable, with a
// sticky halt and a wrapping step counter for the display.
module controle_execucao
  import controle_execucao_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 1000000,
  parameter int LARGURA_CONT    = 16
) (
  input  logic                    clk_alta_f,
  input  logic                    rst,
  input  logic                    clk_baixa_f,
  input  logic                    botao_n,
  input  logic [1:0]              modo,
  input  logic                    parar,
  output logic                    habilita,
  output logic [LARGURA_CONT-1:0] contagem_passos,
  output logic [1:0]              modo_ativo,
  output logic                    parado
);

  logic       lento_s1, lento_s2, lento_s3;
  logic [1:0] modo_s1, modo_s2;
  logic       evento_lento, evento_botao, evento_sel;

  debounce_botao #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_debounce (
    .clk_alta_f  (clk_alta_f),
    .rst         (rst),
    .botao_n     (botao_n),
    .evento_botao(evento_botao)
  );

  // Synchronize the slow clock (plus one flop for edge detect) and the switches.
  always_ff @(posedge clk_alta_f or posedge rst) begin
    if (rst) begin
      lento_s1   <= 1'b0;
      lento_s2   <= 1'b0;
      lento_s3   <= 1'b0;
      modo_s1    <= MODO_PAUSA;
      modo_s2    <= MODO_PAUSA;
      modo_ativo <= MODO_PAUSA;
    end else begin
      lento_s1   <= clk_baixa_f;
      lento_s2   <= lento_s1;
      lento_s3   <= lento_s2;
      modo_s1    <= modo;
      modo_s2    <= modo_s1;
      modo_ativo <= modo_s2;
    end
  end

  assign evento_lento = lento_s2 & ~lento_s3;

  // Only the source matching the active mode passes; others are dropped.
  always_comb begin
    evento_sel = 1'b0;
    case (modo_ativo)
      MODO_LENTO:    evento_sel = evento_lento;
      MODO_MANUAL:   evento_sel = evento_botao;
      MODO_CONTINUO: evento_sel = 1'b1;
      default:       evento_sel = 1'b0;
    endcase
  end

  // Enable, halt and step counter; a same-cycle parar suppresses the event.
  always_ff @(posedge clk_alta_f or posedge rst) begin
    if (rst) begin
      habilita        <= 1'b0;
      parado          <= 1'b0;
      contagem_passos <= '0;
    end else begin
      habilita        <= evento_sel & ~parado & ~parar;
      contagem_passos <= contagem_passos + LARGURA_CONT'(habilita);
      if (parar)
        parado <= 1'b1;
      else if (modo_ativo == MODO_PAUSA)
        parado <= 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_execucao.sv
// Directed bench for controle_execucao with a short debounce window.
module tb_controle_execucao;

  logic       clk_alta_f = 1'b0;
  logic       rst;
  logic       clk_baixa_f;
  logic       botao_n;
  logic [1:0] modo;
  logic       parar;
  logic       habilita;
  logic [3:0] contagem_passos;
  logic [1:0] modo_ativo;
  logic       parado;

  int nchk  = 0;
  int nerr  = 0;
  int npulse = 0;
  int base;

  controle_execucao #(
    .DEBOUNCE_CICLOS(4),
    .LARGURA_CONT   (4)
  ) dut (
    .clk_alta_f     (clk_alta_f),
    .rst            (rst),
    .clk_baixa_f    (clk_baixa_f),
    .botao_n        (botao_n),
    .modo           (modo),
    .parar          (parar),
    .habilita       (habilita),
    .contagem_passos(contagem_passos),
    .modo_ativo     (modo_ativo),
    .parado         (parado)
  );

  always #5 clk_alta_f = ~clk_alta_f;

  // Count enable pulses away from the active edge.
  always @(negedge clk_alta_f)
    if (habilita === 1'b1) npulse++;

  task automatic step();
    @(posedge clk_alta_f);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clk_baixa_f = 1'b0; botao_n = 1'b1; modo = 2'b00; parar = 1'b0;

    // Reset state
    step(); step();
    chk("rst_habilita", 32'(habilita), 0);
    chk("rst_contagem", 32'(contagem_passos), 0);
    chk("rst_modo", 32'(modo_ativo), 0);
    chk("rst_parado", 32'(parado), 0);
    rst = 1'b0;

    // 1: slow mode, one pulse per rising edge, 3-edge latency
    modo = 2'b01;
    step(); step(); step();
    chk("lento_modo", 32'(modo_ativo), 1);
    for (int e = 0; e < 3; e++) begin
      base = npulse;
      clk_baixa_f = 1'b1;
      step(); step();
      chk("lento_cedo", 32'(habilita), 0);
      step();
      chk("lento_pulso", 32'(habilita), 1);
      step();
      chk("lento_fim", 32'(habilita), 0);
      chk("lento_cont", 32'(contagem_passos), 32'(e + 1));
      repeat (6) step();
      clk_baixa_f = 1'b0;
      repeat (10) step();
      chk("lento_npulsos", 32'(npulse - base), 1);
    end

    // 2: manual mode, glitch rejected, one pulse per press, bouncy release
    modo = 2'b10;
    step(); step(); step();
    chk("manual_modo", 32'(modo_ativo), 2);
    base = npulse;
    botao_n = 1'b0; step(); step(); botao_n = 1'b1;
    repeat (10) step();
    chk("manual_glitch", 32'(npulse - base), 0);
    botao_n = 1'b0;
    repeat (20) step();
    chk("manual_press", 32'(npulse - base), 1);
    for (int i = 0; i < 8; i++) begin
      botao_n = i[0] ? 1'b0 : 1'b1;
      step();
    end
    botao_n = 1'b1;
    repeat (10) step();
    chk("manual_bounce", 32'(npulse - base), 1);
    chk("manual_cont", 32'(contagem_passos), 4);

    // 3: continuous mode, counter wraps
    modo = 2'b11;
    step(); step(); step();
    chk("cont_modo", 32'(modo_ativo), 3);
    chk("cont_latencia", 32'(habilita), 0);
    step();
    chk("cont_inicio", 32'(habilita), 1);
    for (int i = 5; i <= 20; i++) begin
      step();
      if (i == 15) chk("cont_15", 32'(contagem_passos), 15);
      if (i == 16) chk("cont_wrap", 32'(contagem_passos), 0);
      if (i == 18) chk("cont_alto", 32'(habilita), 1);
    end
    chk("cont_4", 32'(contagem_passos), 4);

    // 4: halt, kept through LENTO, cleared by PAUSA
    parar = 1'b1; step(); parar = 1'b0;
    chk("halt_habilita", 32'(habilita), 0);
    chk("halt_parado", 32'(parado), 1);
    chk("halt_cont", 32'(contagem_passos), 5);
    step(); step(); step();
    chk("halt_mantem", 32'(habilita), 0);
    modo = 2'b01;
    step(); step(); step();
    chk("halt_lento_modo", 32'(modo_ativo), 1);
    chk("halt_lento_parado", 32'(parado), 1);
    base = npulse;
    clk_baixa_f = 1'b1; repeat (6) step();
    clk_baixa_f = 1'b0; repeat (4) step();
    chk("halt_lento_sem", 32'(npulse - base), 0);
    modo = 2'b00;
    step(); step(); step();
    chk("pausa_ainda", 32'(parado), 1);
    step();
    chk("pausa_limpa", 32'(parado), 0);
    modo = 2'b11;
    step(); step(); step();
    chk("retoma_latencia", 32'(habilita), 0);
    step();
    chk("retoma_pulso", 32'(habilita), 1);
    chk("retoma_cont0", 32'(contagem_passos), 5);
    step();
    chk("retoma_cont1", 32'(contagem_passos), 6);

    // 5: stale button event discarded; parar beats slow edge
    modo = 2'b01;
    repeat (5) step();
    base = npulse;
    botao_n = 1'b0; repeat (10) step();
    botao_n = 1'b1; repeat (10) step();
    chk("lento_botao", 32'(npulse - base), 0);
    modo = 2'b10;
    repeat (10) step();
    chk("manual_modo2", 32'(modo_ativo), 2);
    chk("sem_resto", 32'(npulse - base), 0);
    modo = 2'b01;
    repeat (4) step();
    base = npulse;
    clk_baixa_f = 1'b1;
    step(); step();
    parar = 1'b1; step(); parar = 1'b0;
    chk("parar_vence", 32'(habilita), 0);
    chk("parar_parado", 32'(parado), 1);
    repeat (5) step();
    chk("parar_sem", 32'(npulse - base), 0);
    clk_baixa_f = 1'b0;
    modo = 2'b00;
    repeat (5) step();
    chk("parar_limpo", 32'(parado), 0);

    // 6: reset mid-debounce in continuous mode, then fresh debounce
    modo = 2'b11;
    repeat (5) step();
    chk("pre_rst", 32'(habilita), 1);
    botao_n = 1'b0;
    repeat (4) step();
    rst = 1'b1; modo = 2'b10;
    #1;
    chk("rst2_habilita", 32'(habilita), 0);
    chk("rst2_cont", 32'(contagem_passos), 0);
    chk("rst2_modo", 32'(modo_ativo), 0);
    chk("rst2_parado", 32'(parado), 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("pos_rst", 32'(habilita), 0);
    repeat (5) step();
    chk("pos_rst_debounce", 32'(habilita), 0);
    chk("pos_rst_modo", 32'(modo_ativo), 2);
    step();
    chk("pos_rst_pulso", 32'(habilita), 1);
    step();
    chk("pos_rst_fim", 32'(habilita), 0);
    chk("pos_rst_cont", 32'(contagem_passos), 1);
    botao_n = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
